// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch sequencer:
//   - instruction / opcode widths and the HALT opcode value
//   - controller state enumeration (IDLE, LOAD, FILL, RUN, DONE)
//   - named program identifiers for the eight encrypt/decrypt algorithms
//   - run-cycle counter width used when FETCH_CTRL_CYCLE_COUNT_EN is defined
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  localparam int INSTR_W   = 14;
  localparam int OPCODE_W  = 4;
  localparam int ALG_W     = 3;
  localparam int RUN_CNT_W = 16;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'hF;

  // Program identifiers; the value doubles as the base-address mux select.
  localparam logic [ALG_W-1:0] ALG_ENC_XOR   = 3'd0;
  localparam logic [ALG_W-1:0] ALG_DEC_XOR   = 3'd1;
  localparam logic [ALG_W-1:0] ALG_ENC_SHIFT = 3'd2;
  localparam logic [ALG_W-1:0] ALG_DEC_SHIFT = 3'd3;
  localparam logic [ALG_W-1:0] ALG_ENC_ROT   = 3'd4;
  localparam logic [ALG_W-1:0] ALG_DEC_ROT   = 3'd5;
  localparam logic [ALG_W-1:0] ALG_ENC_ADD   = 3'd6;
  localparam logic [ALG_W-1:0] ALG_DEC_ADD   = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Opcode field of a fetched instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the command-side handshake and the fetch-stage control lines of the
// fetch sequencer.
//   command side : start, alg_id, abort   -> controller
//                  ready, busy, done      <- controller
//   fetch side   : stall, instruccion     -> controller
//                  sel_dir, sel_pc, pc_en, if_valid <- controller
// Modports:
//   slave  - the controller (fetch_ctrl)
//   master - the environment driving commands and providing the ROM word
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;

  logic                                 start;
  logic [fetch_ctrl_pkg::ALG_W-1:0]     alg_id;
  logic                                 abort;
  logic                                 stall;
  logic [fetch_ctrl_pkg::INSTR_W-1:0]   instruccion;
  logic [fetch_ctrl_pkg::ALG_W-1:0]     sel_dir;
  logic                                 sel_pc;
  logic                                 pc_en;
  logic                                 if_valid;
  logic                                 ready;
  logic                                 busy;
  logic                                 done;

  modport slave (
    input  start, alg_id, abort, stall, instruccion,
    output sel_dir, sel_pc, pc_en, if_valid, ready, busy, done
  );

  modport master (
    output start, alg_id, abort, stall, instruccion,
    input  sel_dir, sel_pc, pc_en, if_valid, ready, busy, done
  );

endinterface

// File: rtl/fetch_cycle_counter.sv
// -----------------------------------------------------------------------------
// fetch_cycle_counter
// Saturating run-cycle counter for the fetch sequencer.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, count returns to 0
//   clear  - synchronous clear (accepted program start), wins over inc
//   inc    - count this cycle (controller is in RUN)
//   count  - current value; sticks at all-ones once reached
// -----------------------------------------------------------------------------
module fetch_cycle_counter
  import fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 inc,
  output logic [RUN_CNT_W-1:0] count
);

  logic [RUN_CNT_W-1:0] count_reg;
  logic [RUN_CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count_reg != '1)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. On an accepted start it latches the program
// select onto sel_dir, loads the PC with the program base (LOAD), primes the
// ROM address register (FILL), then streams instructions to decode (RUN)
// until a HALT opcode is seen, pulsing done for one cycle (DONE).
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   bus        - fetch_ctrl_if.slave: start/alg_id/abort/stall/instruccion in,
//                sel_dir/sel_pc/pc_en/if_valid/ready/busy/done out
//   run_cycles - (only with FETCH_CTRL_CYCLE_COUNT_EN) saturating count of
//                RUN cycles of the most recent program
// Build option: define FETCH_CTRL_CYCLE_COUNT_EN to add run_cycles.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_ctrl_if.slave          bus
`ifdef FETCH_CTRL_CYCLE_COUNT_EN
  ,
  output logic [RUN_CNT_W-1:0] run_cycles
`endif
);

  state_t             state_reg;
  state_t             state_next;
  logic [ALG_W-1:0]   sel_dir_reg;
  logic [ALG_W-1:0]   sel_dir_next;

  logic               sel_pc_c;
  logic               pc_en_c;
  logic               if_valid_c;
  logic               ready_c;
  logic               busy_c;
  logic               done_c;
  logic               halt_seen;
  logic [OPCODE_W-1:0] op_match;
  logic [OPCODE_W-1:0] cur_opcode;

  assign cur_opcode = opcode_of(bus.instruccion);

  // Bitwise compare of the opcode field against HALT, reduced below.
  genvar gi;
  generate
    for (gi = 0; gi < OPCODE_W; gi++) begin : g_halt_cmp
      assign op_match[gi] = (cur_opcode[gi] == HALT_OPCODE[gi]);
    end
  endgenerate
  assign halt_seen = &op_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sel_dir_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sel_dir_reg <= sel_dir_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_dir_next = sel_dir_reg;
    sel_pc_c     = 1'b0;
    pc_en_c      = 1'b0;
    if_valid_c   = 1'b0;
    ready_c      = 1'b0;
    busy_c       = 1'b0;
    done_c       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        ready_c = 1'b1;
        // abort in IDLE blocks a simultaneous start
        if (bus.start && !bus.abort) begin
          sel_dir_next = bus.alg_id;
          state_next   = LOAD;
        end
      end
      LOAD: begin
        busy_c     = 1'b1;
        sel_pc_c   = 1'b1;
        pc_en_c    = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        busy_c     = 1'b1;
        pc_en_c    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        // HALT is never issued and freezes the PC even under stall
        if (halt_seen) begin
          state_next = DONE;
        end else begin
          pc_en_c    = !bus.stall;
          if_valid_c = !bus.stall;
        end
      end
      DONE: begin
        busy_c     = 1'b1;
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort overrides every active state and squashes fetch activity.
    if (bus.abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      pc_en_c    = 1'b0;
      if_valid_c = 1'b0;
    end
  end

  assign bus.sel_dir  = sel_dir_reg;
  assign bus.sel_pc   = sel_pc_c;
  assign bus.pc_en    = pc_en_c;
  assign bus.if_valid = if_valid_c;
  assign bus.ready    = ready_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

`ifdef FETCH_CTRL_CYCLE_COUNT_EN
  logic start_accept;
  logic in_run;

  assign start_accept = (state_reg == IDLE) && bus.start && !bus.abort;
  assign in_run       = (state_reg == RUN);

  fetch_cycle_counter u_run_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_accept),
    .inc   (in_run),
    .count (run_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Bench for fetch_ctrl with a behavioural fetch stage (PC + ROM address
// register + 1024-word ROM). Program expectations come from the ROM contents
// and simple issue/stall counting per cycle.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();

`ifdef FETCH_CTRL_CYCLE_COUNT_EN
  logic [RUN_CNT_W-1:0] run_cycles;
`endif

  fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_CTRL_CYCLE_COUNT_EN
    ,
    .run_cycles (run_cycles)
`endif
  );

  // Fetch stage model: program bases spaced 128 words apart.
  function automatic logic [9:0] base_of(input logic [2:0] a);
    return {a, 7'd0};
  endfunction

  logic [INSTR_W-1:0] rom [0:1023];
  logic [9:0] pc_q   = '0;
  logic [9:0] addr_q = '0;

  always @(posedge clk) begin
    if (bus.pc_en) begin
      addr_q <= pc_q;
      pc_q   <= bus.sel_pc ? base_of(bus.sel_dir) : pc_q + 10'd1;
    end
  end
  assign bus.instruccion = rom[addr_q];

  int checks = 0;
  int errors = 0;
  logic [INSTR_W-1:0] exp_q[$];

  typedef struct {
    logic [2:0] alg;
    int         n;
    int         stall_at;
    int         stall_len;
    int         exp_done;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] rand_op();
    logic [3:0] op;
    logic [9:0] arg;
    op  = 4'($urandom_range(0, 14));
    arg = 10'($urandom);
    return {op, arg};
  endfunction

  task automatic load_prog(input logic [2:0] a, input int n);
    logic [INSTR_W-1:0] w;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      w = rand_op();
      rom[base_of(a) + 10'(k)] = w;
      exp_q.push_back(w);
    end
    rom[base_of(a) + 10'(n)] = {HALT_OPCODE, 10'($urandom)};
  endtask

  // One cycle: inputs applied just after the rising edge, outputs sampled at
  // the falling edge of the same cycle.
  task automatic drive(input logic s, input logic [2:0] a, input logic ab, input logic st);
    @(posedge clk);
    #1;
    bus.start  = s;
    bus.alg_id = a;
    bus.abort  = ab;
    bus.stall  = st;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".ready"},    32'(bus.ready),    32'd1);
    chk({nm, ".busy"},     32'(bus.busy),     32'd0);
    chk({nm, ".done"},     32'(bus.done),     32'd0);
    chk({nm, ".sel_dir"},  32'(bus.sel_dir),  32'd0);
    chk({nm, ".sel_pc"},   32'(bus.sel_pc),   32'd0);
    chk({nm, ".pc_en"},    32'(bus.pc_en),    32'd0);
    chk({nm, ".if_valid"}, 32'(bus.if_valid), 32'd0);
  endtask

  // Runs one program from the start cycle (cycle 0) through its done cycle.
  // exp_done < 0 means the done cycle comes from the issue/stall count only.
  task automatic run_prog(input logic [2:0] a, input int n, input int stall_at,
                          input int stall_len, input bit rnd, input int exp_done,
                          input string nm);
    int issued, got, halt_c, sc, dut_done_c, c, want_done;
    bit fin, st, live, strt, ev;
    logic [2:0] ra;
    load_prog(a, n);
    drive(1'b1, a, 1'b0, 1'b0);
    chk($sformatf("%s.ready_at_start", nm), 32'(bus.ready), 32'd1);
    chk($sformatf("%s.busy_at_start", nm),  32'(bus.busy),  32'd0);
    issued = 0; got = 0; halt_c = -1; sc = 0; dut_done_c = -1; fin = 0; c = 1;
    while (!fin && c < 600) begin
      if (c >= 3 && halt_c < 0 && issued == n) halt_c = c;
      live = (c >= 3) && (halt_c < 0);
      if (rnd) begin
        st = (c < 300) && ($urandom_range(0, 3) == 0);
      end else begin
        st = live && (issued == stall_at) && (sc < stall_len);
        if (st) sc++;
      end
      strt = rnd && ($urandom_range(0, 3) == 0);
      ra   = 3'($urandom);
      drive(strt, ra, 1'b0, st);
      ev = live && !st;
      chk($sformatf("%s.busy@%0d", nm, c),     32'(bus.busy),     32'd1);
      chk($sformatf("%s.ready@%0d", nm, c),    32'(bus.ready),    32'd0);
      chk($sformatf("%s.sel_dir@%0d", nm, c),  32'(bus.sel_dir),  32'(a));
      chk($sformatf("%s.sel_pc@%0d", nm, c),   32'(bus.sel_pc),   32'(c == 1));
      chk($sformatf("%s.pc_en@%0d", nm, c),    32'(bus.pc_en),    32'(c == 1 || c == 2 || ev));
      chk($sformatf("%s.if_valid@%0d", nm, c), 32'(bus.if_valid), 32'(ev));
      chk($sformatf("%s.done@%0d", nm, c),     32'(bus.done),     32'(halt_c >= 0 && c == halt_c + 1));
      if (live) chk($sformatf("%s.instr@%0d", nm, c), 32'(bus.instruccion), 32'(exp_q[issued]));
      if (bus.done === 1'b1) dut_done_c = c;
      if (bus.if_valid === 1'b1) got++;
      if (ev) issued++;
      if (halt_c >= 0 && c == halt_c + 1) fin = 1;
      c++;
    end
    chk($sformatf("%s.finished_in_budget", nm), 32'(fin), 32'd1);
    chk($sformatf("%s.issue_count", nm), 32'(got), 32'(n));
    want_done = (exp_done >= 0) ? exp_done : halt_c + 1;
    chk($sformatf("%s.done_cycle", nm), 32'(dut_done_c), 32'(want_done));
`ifdef FETCH_CTRL_CYCLE_COUNT_EN
    chk($sformatf("%s.run_cycles", nm), 32'(run_cycles), 32'(halt_c - 2));
`endif
    $display("prog %s alg=%0d n=%0d issued=%0d done_cycle=%0d", nm, a, n, got, dut_done_c);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] last_alg;
    bus.start = 1'b0; bus.alg_id = '0; bus.abort = 1'b0; bus.stall = 1'b0;
    for (int k = 0; k < 1024; k++) rom[k] = rand_op();

    vecs[0] = '{alg: 3'd3, n: 5, stall_at: 99, stall_len: 0, exp_done: 9};
    vecs[1] = '{alg: 3'd0, n: 2, stall_at: 1,  stall_len: 3, exp_done: 9};
    vecs[2] = '{alg: 3'd5, n: 4, stall_at: 2,  stall_len: 3, exp_done: 11};
    vecs[3] = '{alg: 3'd7, n: 0, stall_at: 99, stall_len: 0, exp_done: 4};
    vecs[4] = '{alg: 3'd1, n: 1, stall_at: 0,  stall_len: 2, exp_done: 7};
    vecs[5] = '{alg: 3'd6, n: 4, stall_at: 2,  stall_len: 2, exp_done: 10};
    vecs[6] = '{alg: 3'd2, n: 8, stall_at: 7,  stall_len: 1, exp_done: 13};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table programs, started back to back (next start two cycles after HALT)
    for (int i = 0; i < 7; i++) begin
      run_prog(vecs[i].alg, vecs[i].n, vecs[i].stall_at, vecs[i].stall_len,
               1'b0, vecs[i].exp_done, $sformatf("vec%0d", i));
    end
    last_alg = vecs[6].alg;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("idle_after.ready", 32'(bus.ready), 32'd1);
    chk("idle_after.busy",  32'(bus.busy),  32'd0);
    chk("idle_after.done",  32'(bus.done),  32'd0);

    // start together with abort in IDLE is dropped
    drive(1'b1, 3'd4, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("start_abort_idle.ready",   32'(bus.ready),   32'd1);
    chk("start_abort_idle.busy",    32'(bus.busy),    32'd0);
    chk("start_abort_idle.sel_dir", 32'(bus.sel_dir), 32'(last_alg));
    $display("seq start_abort_idle sel_dir=%0d", bus.sel_dir);

    // abort during FILL
    load_prog(3'd5, 6);
    drive(1'b1, 3'd5, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    chk("abort_fill.pc_en",    32'(bus.pc_en),    32'd0);
    chk("abort_fill.if_valid", 32'(bus.if_valid), 32'd0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("abort_fill.ready",   32'(bus.ready),   32'd1);
    chk("abort_fill.busy",    32'(bus.busy),    32'd0);
    chk("abort_fill.done",    32'(bus.done),    32'd0);
    chk("abort_fill.sel_dir", 32'(bus.sel_dir), 32'd5);
    $display("seq abort_fill ready=%0d", bus.ready);

    // abort during RUN
    load_prog(3'd2, 10);
    drive(1'b1, 3'd2, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 3'd0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("abort_run.instr2", 32'(bus.instruccion), 32'(exp_q[1]));
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    chk("abort_run.pc_en",    32'(bus.pc_en),    32'd0);
    chk("abort_run.if_valid", 32'(bus.if_valid), 32'd0);
    chk("abort_run.busy",     32'(bus.busy),     32'd1);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("abort_run.ready", 32'(bus.ready), 32'd1);
    chk("abort_run.done",  32'(bus.done),  32'd0);
    $display("seq abort_run ready=%0d", bus.ready);

    // asynchronous reset while in RUN
    load_prog(3'd4, 10);
    drive(1'b1, 3'd4, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("pre_reset.if_valid", 32'(bus.if_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    $display("seq async_reset ready=%0d", bus.ready);

    // Randomized programs with random stalls and ignored start pulses
    for (int i = 0; i < 25; i++) begin
      run_prog(3'($urandom), $urandom_range(0, 12), 0, 0, 1'b1, -1,
               $sformatf("rnd%0d", i));
    end

`ifdef FETCH_CTRL_CYCLE_COUNT_EN
    // Program without HALT long enough to saturate the counter
    for (int k = 0; k < 1024; k++) rom[k] = rand_op();
    drive(1'b1, 3'd0, 1'b0, 1'b0);
    repeat (70010) drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("saturate.run_cycles", 32'(run_cycles), 32'hFFFF);
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    chk("saturate.hold_after_abort", 32'(run_cycles), 32'hFFFF);
    $display("seq saturate run_cycles=%0h", run_cycles);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage of the vector processor. Accepts an algorithm-start request (one of eight encrypt/decrypt programs), drives the fetch stage's `sel_dir`/`sel_pc` select lines and PC/ROM enable to jump to the program base and stream instructions. It also qualifies each fetched instruction for decode, honours decode stalls, and stops the program on a HALT opcode. It sits between the top-level command interface and the fetch stage.

## Interface
- `INSTR_W`, 14: instruction width.
- `OPCODE_W`, 4: opcode field width, `instruccion[INSTR_W-1 -: OPCODE_W]`.
- `HALT_OPCODE`, 4'hF: opcode that terminates a program.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to run program `alg_id`; sampled only when `ready`=1.
- `alg_id` input 3: program select, 0..7 (encrypt/decrypt xor, shift, circular shift, add).
- `abort` input 1: cancel current program.
- `stall` input 1: decode cannot accept an instruction this cycle.
- `instruccion` input INSTR_W: fetch-stage ROM output.
- `sel_dir` output 3: base-address mux select, to fetch stage.
- `sel_pc` output 1: 1 = PC loads base address, 0 = PC+1.
- `pc_en` output 1: enable for the PC register and ROM address register; when 0 both hold.
- `if_valid` output 1: `instruccion` is a live instruction for decode this cycle.
- `ready` output 1: idle, start accepted.
- `busy` output 1: program in progress.
- `done` output 1: one-cycle pulse on normal HALT completion.

## Operation
- States: IDLE, LOAD, FILL, RUN, DONE.
- IDLE: `ready`=1, `pc_en`=0, `sel_pc`=0, `if_valid`=0. `start`=1 → latch `alg_id` into `sel_dir`, go LOAD.
- LOAD (1 cycle): `sel_pc`=1, `pc_en`=1; PC loads base at cycle end. → FILL.
- FILL (1 cycle): `sel_pc`=0, `pc_en`=1; ROM captures base address, PC becomes base+1. → RUN.
- RUN: `sel_pc`=0, `pc_en`=!`stall`, `if_valid`=!`stall`, except on HALT.
- RUN HALT: `instruccion` opcode == `HALT_OPCODE` → `if_valid`=0 (HALT never issued), `pc_en`=0, go DONE. This happens regardless of `stall`.
- DONE (1 cycle): `done`=1, `pc_en`=0. → IDLE.
- `busy`=1 in LOAD, FILL, RUN, DONE.
- `abort`=1 in any non-IDLE state → IDLE next edge; `if_valid` and `pc_en` forced 0 that cycle; no `done` pulse.
- `start` outside IDLE is ignored, not queued. `start`+`abort` together in IDLE: abort wins, remain IDLE.
- `sel_dir` holds the last latched `alg_id` until the next accepted start.
- PC wrap 1023→0 is not detected; a program without HALT runs until `abort`.
- Reset mid-program: immediate return to IDLE with reset output values; fetch stage PC content is don't-care.

## Timing
- Reset values: state IDLE, `sel_dir`=0, `sel_pc`=0, `pc_en`=0, `if_valid`=0, `busy`=0, `done`=0, `ready`=1.
- All outputs are decoded from registered state and latched `sel_dir`. The exceptions are `pc_en`/`if_valid` in RUN, which are combinational from `stall` and the opcode compare.
- ROM latency is one cycle: `instruccion` in cycle t equals ROM[PC at end of cycle t-1] when `pc_en` was 1; it holds while `pc_en`=0.
- Latency: `start` accepted in cycle 0 → LOAD cycle 1, FILL cycle 2, first `if_valid` (ROM[base]) in cycle 3.
- With no stalls, one instruction per cycle. A stall of N cycles delays the next instruction by exactly N cycles and holds `instruccion` stable.
- HALT in cycle t → `done` in cycle t+1, `ready` in cycle t+2. Back-to-back start is accepted in cycle t+2.

## Configuration
- `FETCH_CTRL_CYCLE_COUNT_EN` defined: adds output `run_cycles` [15:0].
  - Cleared on accepted start; increments every RUN cycle, stalls included.
  - Saturates at 16'hFFFF and holds after DONE/abort until next start. Reset value is 0.
- Undefined: no port, no counter logic; all other behaviour identical.

## Structure
- Shared package `fetch_ctrl_pkg`: state enum (IDLE/LOAD/FILL/RUN/DONE), `HALT_OPCODE`, `OPCODE_W`, `INSTR_W`, algorithm IDs 0..7 as named constants.
- One natural sub-module: `fetch_cycle_counter`, the saturating 16-bit counter, instantiated only under `FETCH_CTRL_CYCLE_COUNT_EN`.

## Test plan
- Reset released, `start`=1 with `alg_id`=3 → `sel_dir`=3; `sel_pc`=1 in cycle 1 only; first `if_valid` in cycle 3 with ROM[base3]; `busy`=1 from cycle 1.
- HALT at base+5, no stall → exactly 5 `if_valid` cycles; HALT not issued; `done` pulse 1 cycle; `ready`=1 two cycles after HALT.
- `stall`=1 for 3 cycles after the 2nd instruction → `pc_en`=0 and `if_valid`=0 for 3 cycles, `instruccion` stable; 3rd instruction follows with no loss or duplication.
- `abort` during FILL and during RUN → IDLE next edge, no `done`; `start` in same cycle as `abort` in IDLE is ignored.
- `start` pulsed in RUN with a different `alg_id` → ignored, `sel_dir` unchanged. `rst_n` low mid-RUN → all outputs to reset values asynchronously.
- With `FETCH_CTRL_CYCLE_COUNT_EN`: program of 4 instructions + 2 stall cycles → `run_cycles`=7 after DONE. Forced 70000-cycle run → `run_cycles`=16'hFFFF.
